bcd_scan_display: RTL and testbench
===================================

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 Parameter DIV_BITS, default 17, sets prescaler width; dwell per digit is 2^DIV_BITS clk cycles.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 load  input  1  when high at a rising edge, capture bcd_in into the shadow register.
REQ-005 bcd_in  input  16  four BCD digits from counter stage; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 blank_lz  input  1  leading-zero blanking enable; sampled every cycle.
REQ-007 seg  output  7  active-low segments {g,f,e,d,c,b,a}; registered.
REQ-008 an  output  4  active-low digit enables, one-hot-low; an[i] drives digit i; registered.

Function
REQ-009 Prescaler: DIV_BITS-bit up-counter, free-running, wraps all-ones -> 0; tick asserted when counter is all-ones.
REQ-010 Digit index: 2-bit counter, increments on the edge where tick is high; wraps 3 -> 0; otherwise holds.
REQ-011 Shadow register: 16 bits, loaded from bcd_in on load; otherwise holds; display never reads bcd_in directly.
REQ-012 Output register: each edge, an <= ~(1 << index) and seg <= decode of shadow digit[index]; latency from index/shadow change to seg/an is exactly one cycle.
REQ-013 Decode: 0..9 -> standard active-low patterns (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000).
REQ-014 Invalid digit (10..15) -> dash, segment g only (0111111); never blanked.
REQ-015 Leading-zero blanking: with blank_lz=1, digit i (i=3,2,1) shows 1111111 when it and every higher digit are zero; digit 0 never blanked; with blank_lz=0 no blanking.
REQ-016 An is driven during a blanked digit; only seg is blanked.
REQ-017 load coincident with tick: both take effect on the same edge; the next output cycle uses the new index and new shadow value.
REQ-018 load held high continuously: shadow tracks bcd_in each cycle, one-cycle delay.

Reset
REQ-019 While rst=0: prescaler=0, index=0, shadow=16'h0000, seg=1111111, an=1111 (display dark).
REQ-020 Reset assertion mid-scan forces REQ-019 values immediately, independent of clk.
REQ-021 First edge after rst release: an=1110, seg=1000000 (digit 0 showing 0).

Structure
REQ-022 Shared package holds the ten digit patterns, SEG_DASH, SEG_BLANK, and default DIV_BITS.
REQ-023 One combinational sub-module seg7_decode (4-bit digit + blank flag -> 7-bit pattern); instantiated once, fed by the index mux.
REQ-024 No other sub-modules; prescaler, index, shadow and output registers live in bcd_scan_display.

Verification (bench uses DIV_BITS=2)
REQ-025 Reset/release: rst=0 -> seg=1111111, an=1111; release -> next edge an=1110, seg=1000000.
REQ-026 Scan order: load bcd_in=16'h1259, blank_lz=0 -> an cycles 1110,1101,1011,0111 every 4 clks with seg 0010000,0010010,0100100,1111001; then 1110 again.
REQ-027 Blanking: load 16'h0070, blank_lz=1 -> digit3 and digit2 1111111, digit1 1111000, digit0 1000000; load 16'h0000 -> digits 3..1 blank, digit 0 1000000.
REQ-028 Invalid: load 16'hA0F3 -> digits 3 and 1 show 0111111, digit 2 1000000, digit 0 0110000, blank_lz=1 does not blank digit 2.
REQ-029 Load on tick edge: assert load with bcd_in=16'h0008 on the edge index goes 3->0 -> next cycle an=1110, seg=0000000.
REQ-030 Async reset mid-scan: drop rst between edges while an=1011 -> seg=1111111, an=1111 before next edge; shadow reads 0 after release.

Source files
------------

// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the multiplexed 4-digit BCD display: segment patterns
// (active-low {g,f,e,d,c,b,a}) and the default prescaler width.
package bcd_scan_display_pkg;

  localparam int unsigned DIV_BITS_DEFAULT = 17;

  localparam logic [6:0] SEG_D0 = 7'b1000000;
  localparam logic [6:0] SEG_D1 = 7'b1111001;
  localparam logic [6:0] SEG_D2 = 7'b0100100;
  localparam logic [6:0] SEG_D3 = 7'b0110000;
  localparam logic [6:0] SEG_D4 = 7'b0011001;
  localparam logic [6:0] SEG_D5 = 7'b0010010;
  localparam logic [6:0] SEG_D6 = 7'b0000010;
  localparam logic [6:0] SEG_D7 = 7'b1111000;
  localparam logic [6:0] SEG_D8 = 7'b0000000;
  localparam logic [6:0] SEG_D9 = 7'b0010000;

  // Shown for non-BCD nibbles (segment g only lit)
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Extract nibble idx from a packed 4-digit BCD word
  function automatic logic [3:0] bcd_nibble(input logic [15:0] word,
                                            input logic [1:0]  idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-7-segment decoder with blanking; non-BCD inputs show
// a dash and are never blanked.
module seg7_decode
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Pattern lookup; blanking only applies to valid BCD digits
  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0: seg_o = SEG_D0;
      4'd1: seg_o = SEG_D1;
      4'd2: seg_o = SEG_D2;
      4'd3: seg_o = SEG_D3;
      4'd4: seg_o = SEG_D4;
      4'd5: seg_o = SEG_D5;
      4'd6: seg_o = SEG_D6;
      4'd7: seg_o = SEG_D7;
      4'd8: seg_o = SEG_D8;
      4'd9: seg_o = SEG_D9;
      default: seg_o = SEG_DASH;
    endcase
    if (blank_i && (digit_i <= 4'd9)) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 4-digit 7-segment driver: a free-running prescaler steps
// the digit index, a shadow register holds the displayed value, and seg/an
// are registered one cycle behind the index/shadow state.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int unsigned DIV_BITS = DIV_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  logic [DIV_BITS-1:0] presc_q, presc_d;
  logic [1:0]          idx_q, idx_d;
  logic [15:0]         shadow_q, shadow_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          an_q, an_d;

  logic                tick;
  logic [3:0]          cur_digit;
  logic                lead_zero;
  logic                blank;
  logic                z3, z2, z1;

  // Next-state for prescaler, digit index and shadow register
  always_comb begin
    tick     = &presc_q;
    presc_d  = presc_q + DIV_BITS'(1);
    idx_d    = tick ? (idx_q + 2'd1) : idx_q;
    shadow_d = load ? bcd_in : shadow_q;
  end

  // Leading-zero detection for the currently selected digit
  always_comb begin
    z3 = (shadow_q[15:12] == 4'd0);
    z2 = (shadow_q[11:8]  == 4'd0);
    z1 = (shadow_q[7:4]   == 4'd0);
    lead_zero = 1'b0;
    case (idx_q)
      2'd3:    lead_zero = z3;
      2'd2:    lead_zero = z3 & z2;
      2'd1:    lead_zero = z3 & z2 & z1;
      default: lead_zero = 1'b0;
    endcase
    blank     = blank_lz & lead_zero;
    cur_digit = bcd_nibble(shadow_q, idx_q);
  end

  seg7_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  // Digit enable for the selected index (active-low one-hot)
  always_comb begin
    an_d = ~(4'b0001 << idx_q);
  end

  // All state registers; reset leaves the display dark
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display with DIV_BITS=2 (4-cycle dwell).
module tb_bcd_scan_display;

  localparam int unsigned DWELL = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;

  int tests;
  int fails;

  bcd_scan_display #(.DIV_BITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Segment pattern digit i of value v must show, from the display rules
  function automatic logic [6:0] model_seg(input int v, input int i, input bit bl);
    int d;
    int upper;
    d = (v >> (4 * i)) % 16;
    upper = v >> (4 * i);
    if (d > 9) return 7'b0111111;
    if (bl && i > 0 && upper == 0) return 7'b1111111;
    return pat(d);
  endfunction

  int          m_edges;   // edges since reset release
  int          m_shadow;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  bit          m_valid;

  initial m_valid = 1'b0;

  // Model advances on each edge; reset is asynchronous
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edges  = 0;
      m_shadow = 0;
      exp_seg  = 7'b1111111;
      exp_an   = 4'b1111;
      m_valid  = 1'b1;
    end else begin
      int i;
      i = (m_edges / DWELL) % 4;
      exp_seg = model_seg(m_shadow, i, blank_lz);
      exp_an  = 4'b1111;
      exp_an[i] = 1'b0;
      if (load) m_shadow = int'(bcd_in);
      m_edges++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (seg !== exp_seg || an !== exp_an) begin
        fails++;
        $display("FAIL model_cmp t=%0t seg=%b an=%b required seg=%b an=%b",
                 $time, seg, an, exp_seg, exp_an);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [6:0] s, input logic [3:0] a);
    tests++;
    if (seg !== s || an !== a) begin
      fails++;
      $display("FAIL %s seg=%b an=%b required seg=%b an=%b", name, seg, an, s, a);
    end
  endtask

  task automatic load_value(input logic [15:0] v);
    @(negedge clk);
    load   = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Let the new value settle, then capture one full scan (16 cycles)
  task automatic scan_check(input string name, input logic [6:0] e3,
                            input logic [6:0] e2, input logic [6:0] e1,
                            input logic [6:0] e0);
    logic [6:0] got [4];
    int         cnt [4];
    logic [3:0] prev;
    bit         order_ok;
    logic [6:0] exp_arr [4];
    exp_arr[0] = e0; exp_arr[1] = e1; exp_arr[2] = e2; exp_arr[3] = e3;
    for (int k = 0; k < 4; k++) begin
      got[k] = 7'bx;
      cnt[k] = 0;
    end
    order_ok = 1'b1;
    repeat (20) @(negedge clk);
    prev = an;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (an == ~(4'b0001 << k)) begin
          got[k] = seg;
          cnt[k]++;
        end
      end
      if (an != prev && an != {prev[2:0], prev[3]}) order_ok = 1'b0;
      prev = an;
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp_arr[k] || cnt[k] != 4) begin
        fails++;
        $display("FAIL %s digit%0d seg=%b dwell=%0d required seg=%b dwell=4",
                 name, k, got[k], cnt[k], exp_arr[k]);
      end
    end
    tests++;
    if (!order_ok) begin
      fails++;
      $display("FAIL %s scan_order an sequence not 1110->1101->1011->0111", name);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (an == target) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_an an=%b required %b within 40 cycles", an, target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int run;
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    load     = 1'b0;
    bcd_in   = '0;
    blank_lz = 1'b0;

    // model pinning: hand-computed patterns
    tests++;
    if (model_seg(16'h0070, 2, 1'b1) !== 7'b1111111 ||
        model_seg(16'h0070, 1, 1'b1) !== 7'b1111000 ||
        model_seg(16'hA0F3, 2, 1'b1) !== 7'b1000000 ||
        model_seg(16'hA0F3, 3, 1'b1) !== 7'b0111111) begin
      fails++;
      $display("FAIL model_pin reference model patterns wrong");
    end

    // reset and release
    repeat (3) @(negedge clk);
    check("reset_dark", 7'b1111111, 4'b1111);
    rst = 1'b1;
    @(negedge clk);
    check("first_edge", 7'b1000000, 4'b1110);

    // scan order, no blanking
    load_value(16'h1259);
    scan_check("scan_1259", 7'b1111001, 7'b0100100, 7'b0010010, 7'b0010000);

    // leading-zero blanking
    blank_lz = 1'b1;
    load_value(16'h0070);
    scan_check("blank_0070", 7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000);
    load_value(16'h0000);
    scan_check("blank_0000", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);

    // invalid digits, blanking enabled
    load_value(16'hA0F3);
    scan_check("invalid_A0F3", 7'b0111111, 7'b1000000, 7'b0111111, 7'b0110000);

    // load coincident with the 3->0 tick edge
    blank_lz = 1'b0;
    load_value(16'h1259);
    wait_an(4'b1011, ok);
    wait_an(4'b0111, ok);
    repeat (2) @(negedge clk);   // third 0111 sample; next edge is the tick
    load   = 1'b1;
    bcd_in = 16'h0008;
    @(negedge clk);
    load   = 1'b0;
    check("tick_edge_pre", 7'b1111001, 4'b0111);
    @(negedge clk);
    check("load_on_tick", 7'b0000000, 4'b1110);

    // asynchronous reset mid-scan
    load_value(16'h4321);
    wait_an(4'b1011, ok);
    #2 rst = 1'b0;
    #1 check("async_reset", 7'b1111111, 4'b1111);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_edge", 7'b1000000, 4'b1110);
    scan_check("post_reset_shadow", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);

    // randomized traffic checked by the model every cycle
    for (run = 0; run < 600; run++) begin
      @(negedge clk);
      load = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < 4; k++) begin
        bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
    end
    load = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
